// File: rtl/udp_arb_pkg.sv
// -----------------------------------------------------------------------------
// udp_arb_pkg
// Shared definitions for the UDP TX metadata/payload arbiter and related
// blocks (the RX demux reuses rr_priority_select and grant_width).
//   arb_state_e     : arbiter FSM states (IDLE, META, DATA)
//   META_WIDTH_DEF  : default UDP metadata width in bits
//   DATA_WIDTH_DEF  : default payload width in bits
//   grant_width()   : bits needed to hold a port index, never less than 1
// -----------------------------------------------------------------------------
package udp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        META = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam int META_WIDTH_DEF = 176;
    localparam int DATA_WIDTH_DEF = 512;

    // A single-port build still carries a 1-bit index so every port list
    // stays well formed.
    function automatic int grant_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// -----------------------------------------------------------------------------
// rr_priority_select
// Combinational round-robin search: returns the first requesting index when
// scanning ptr_i, ptr_i+1, ... wrapping modulo NUM_PORTS.
// Ports:
//   req_i   in  NUM_PORTS  request vector
//   ptr_i   in  IDX_W      index searched first (must be < NUM_PORTS)
//   found_o out 1          at least one request is set
//   idx_o   out IDX_W      winning index (0 when found_o is low)
// -----------------------------------------------------------------------------
module rr_priority_select
    import udp_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = grant_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic                 found_o,
    output logic [IDX_W-1:0]     idx_o
);

    // cand_idx[k] is the port examined at search offset k.
    logic [IDX_W-1:0] cand_idx [NUM_PORTS];

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
        // One extra bit so ptr + offset cannot overflow before the wrap.
        logic [IDX_W:0] sum;
        assign sum = {1'b0, ptr_i} + (IDX_W+1)'(gi);
        assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_PORTS))
                            ? IDX_W'(sum - (IDX_W+1)'(NUM_PORTS))
                            : sum[IDX_W-1:0];
    end

    // Walk offsets from the highest down so the smallest offset wins last.
    // Requests are matched by comparison rather than variable bit-select so
    // a 1-port build never indexes a 1-bit vector with a wider index.
    always_comb begin
        logic hit;
        found_o = 1'b0;
        idx_o   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            hit = 1'b0;
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (req_i[j] && (cand_idx[k] == IDX_W'(j))) begin
                    hit = 1'b1;
                end
            end
            if (hit) begin
                found_o = 1'b1;
                idx_o   = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/udp_tx_meta_arbiter.sv
// -----------------------------------------------------------------------------
// udp_tx_meta_arbiter
// Shares one UDP TX path (metadata stream + payload stream) between NUM_PORTS
// requesters with packet-granular round-robin. A port is picked on its
// metadata valid; the grant then covers one metadata beat followed by all of
// that packet's payload beats through tlast, so downstream never sees
// interleaved packets. Forwarding is a pure mux on the registered grant:
// no buffering, zero latency, ready passes straight back to the winner.
// Ports:
//   aclk, areset                          clock, synchronous active-high reset
//   s_meta_valid/ready/data               per-port metadata (slice i = port i)
//   s_data_valid/ready/data/keep/last     per-port payload
//   m_meta_valid/ready/data               shared metadata output
//   m_data_valid/ready/data/keep/last     shared payload output
//   grant_id                              current or most recent grant
//   busy                                  high while in META or DATA
// -----------------------------------------------------------------------------
module udp_tx_meta_arbiter
    import udp_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int META_WIDTH = META_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                              aclk,
    input  logic                              areset,

    input  logic [NUM_PORTS-1:0]              s_meta_valid,
    output logic [NUM_PORTS-1:0]              s_meta_ready,
    input  logic [NUM_PORTS*META_WIDTH-1:0]   s_meta_data,

    input  logic [NUM_PORTS-1:0]              s_data_valid,
    output logic [NUM_PORTS-1:0]              s_data_ready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_data_data,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_data_keep,
    input  logic [NUM_PORTS-1:0]              s_data_last,

    output logic                              m_meta_valid,
    input  logic                              m_meta_ready,
    output logic [META_WIDTH-1:0]             m_meta_data,

    output logic                              m_data_valid,
    input  logic                              m_data_ready,
    output logic [DATA_WIDTH-1:0]             m_data_data,
    output logic [DATA_WIDTH/8-1:0]           m_data_keep,
    output logic                              m_data_last,

    output logic [grant_width(NUM_PORTS)-1:0] grant_id,
    output logic                              busy
);

    localparam int GW = grant_width(NUM_PORTS);
    localparam int KW = DATA_WIDTH / 8;

    arb_state_e       state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    rr_ptr_q, rr_ptr_d;

    logic             pick_found;
    logic [GW-1:0]    pick_idx;

    logic [NUM_PORTS-1:0] grant_sel;
    logic                 meta_valid_g;
    logic                 data_valid_g;
    logic                 data_last_g;
    logic [META_WIDTH-1:0] meta_data_g;
    logic [DATA_WIDTH-1:0] data_data_g;
    logic [KW-1:0]         data_keep_g;

    rr_priority_select #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (GW)
    ) u_rr_select (
        .req_i   (s_meta_valid),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // One-hot decode of the registered grant drives every mux below.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_grant_sel
        assign grant_sel[gi] = (grant_q == GW'(gi));
    end

    assign meta_valid_g = |(s_meta_valid & grant_sel);
    assign data_valid_g = |(s_data_valid & grant_sel);
    assign data_last_g  = |(s_data_last  & grant_sel);

    // AND-OR style wide muxes on the granted slice.
    always_comb begin
        meta_data_g = '0;
        data_data_g = '0;
        data_keep_g = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (grant_sel[j]) begin
                meta_data_g = s_meta_data[j*META_WIDTH +: META_WIDTH];
                data_data_g = s_data_data[j*DATA_WIDTH +: DATA_WIDTH];
                data_keep_g = s_data_keep[j*KW +: KW];
            end
        end
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = META;
                end
            end
            META: begin
                // A dropped meta valid simply stalls here; the grant is kept.
                if (meta_valid_g && m_meta_ready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (data_valid_g && m_data_ready && data_last_g) begin
                    state_d = IDLE;
                    // The port just served drops to lowest priority.
                    rr_ptr_d = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        s_meta_ready = '0;
        s_data_ready = '0;
        m_meta_valid = 1'b0;
        m_data_valid = 1'b0;
        case (state_q)
            META: begin
                m_meta_valid = meta_valid_g;
                s_meta_ready = grant_sel & {NUM_PORTS{m_meta_ready}};
            end
            DATA: begin
                m_data_valid = data_valid_g;
                s_data_ready = grant_sel & {NUM_PORTS{m_data_ready}};
            end
            default: ;
        endcase
    end

    assign m_meta_data = meta_data_g;
    assign m_data_data = data_data_g;
    assign m_data_keep = data_keep_g;
    assign m_data_last = data_last_g;
    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_udp_tx_meta_arbiter.sv
// -----------------------------------------------------------------------------
// tb_udp_tx_meta_arbiter
// Directed bench for udp_tx_meta_arbiter (4 ports, 176/512-bit widths).
// Requester sources are small per-port FIFOs of metadata and payload beats
// that advance on their own handshakes. Each directed step pushes the
// packets it expects downstream, in expected arbitration order, onto a
// scoreboard; every downstream handshake pops and compares one entry.
// -----------------------------------------------------------------------------
module tb_udp_tx_meta_arbiter;

    localparam int NP    = 4;
    localparam int MW    = 176;
    localparam int DW    = 512;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 64;

    logic                 aclk = 1'b0;
    logic                 areset;
    logic [NP-1:0]        s_meta_valid;
    logic [NP-1:0]        s_meta_ready;
    logic [NP*MW-1:0]     s_meta_data;
    logic [NP-1:0]        s_data_valid;
    logic [NP-1:0]        s_data_ready;
    logic [NP*DW-1:0]     s_data_data;
    logic [NP*KW-1:0]     s_data_keep;
    logic [NP-1:0]        s_data_last;
    logic                 m_meta_valid;
    logic                 m_meta_ready;
    logic [MW-1:0]        m_meta_data;
    logic                 m_data_valid;
    logic                 m_data_ready;
    logic [DW-1:0]        m_data_data;
    logic [KW-1:0]        m_data_keep;
    logic                 m_data_last;
    logic [1:0]           grant_id;
    logic                 busy;

    always #5 aclk = ~aclk;

    udp_tx_meta_arbiter #(
        .NUM_PORTS  (NP),
        .META_WIDTH (MW),
        .DATA_WIDTH (DW)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_meta_valid (s_meta_valid),
        .s_meta_ready (s_meta_ready),
        .s_meta_data  (s_meta_data),
        .s_data_valid (s_data_valid),
        .s_data_ready (s_data_ready),
        .s_data_data  (s_data_data),
        .s_data_keep  (s_data_keep),
        .s_data_last  (s_data_last),
        .m_meta_valid (m_meta_valid),
        .m_meta_ready (m_meta_ready),
        .m_meta_data  (m_meta_data),
        .m_data_valid (m_data_valid),
        .m_data_ready (m_data_ready),
        .m_data_data  (m_data_data),
        .m_data_keep  (m_data_keep),
        .m_data_last  (m_data_last),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    // Source FIFOs.
    logic [MW-1:0] sm [NP][DEPTH];
    logic [DW-1:0] sd [NP][DEPTH];
    logic [KW-1:0] sk [NP][DEPTH];
    logic          sl [NP][DEPTH];
    int            sm_wr [NP];
    int            sm_rd [NP];
    int            sd_wr [NP];
    int            sd_rd [NP];
    logic [NP-1:0] hold_meta = '0;

    // Scoreboard.
    typedef struct { int port; logic [MW-1:0] meta; } exp_meta_t;
    typedef struct { logic [DW-1:0] d; logic [KW-1:0] k; logic l; } exp_beat_t;
    exp_meta_t exp_meta_q[$];
    exp_beat_t exp_beat_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int pid      = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [MW-1:0] meta_of(input int p, input int id);
        logic [MW-1:0] m;
        m = '0;
        m[7:0]        = 8'hA5;
        m[15:8]       = 8'(p);
        m[23:16]      = 8'(id);
        m[MW-1:MW-8]  = 8'h5C;
        return m;
    endfunction

    function automatic logic [DW-1:0] data_of(input int p, input int id, input int b);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = {8'(p), 8'(id), 8'(b), 8'(i)};
        return d;
    endfunction

    function automatic logic [KW-1:0] keep_of(input int id, input int b, input int nb);
        logic [KW-1:0] ones;
        ones = '1;
        return (b == nb - 1) ? (ones >> ((id % 60) + 1)) : ones;
    endfunction

    // Queue a packet at port p's source (nb beats) and push the metadata plus
    // the first nexp beats onto the scoreboard.
    task automatic pkt(input int p, input int nb, input int nexp);
        pid++;
        sm[p][sm_wr[p]] = meta_of(p, pid);
        sm_wr[p]++;
        exp_meta_q.push_back('{port: p, meta: meta_of(p, pid)});
        for (int b = 0; b < nb; b++) begin
            sd[p][sd_wr[p]] = data_of(p, pid, b);
            sk[p][sd_wr[p]] = keep_of(pid, b, nb);
            sl[p][sd_wr[p]] = (b == nb - 1);
            sd_wr[p]++;
            if (b < nexp)
                exp_beat_q.push_back('{d: data_of(p, pid, b), k: keep_of(pid, b, nb), l: (b == nb - 1)});
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            s_meta_valid[p]          = (sm_rd[p] < sm_wr[p]) && !hold_meta[p];
            s_meta_data[p*MW +: MW]  = '0;
            if (sm_rd[p] < sm_wr[p]) s_meta_data[p*MW +: MW] = sm[p][sm_rd[p]];
            s_data_valid[p]          = (sd_rd[p] < sd_wr[p]);
            s_data_data[p*DW +: DW]  = '0;
            s_data_keep[p*KW +: KW]  = '0;
            s_data_last[p]           = 1'b0;
            if (sd_rd[p] < sd_wr[p]) begin
                s_data_data[p*DW +: DW] = sd[p][sd_rd[p]];
                s_data_keep[p*KW +: KW] = sk[p][sd_rd[p]];
                s_data_last[p]          = sl[p][sd_rd[p]];
            end
        end
    endtask

    // One clock: sample at the falling edge, score handshakes, then advance
    // sources just after the rising edge.
    task automatic cycle();
        logic [NP-1:0] hm;
        logic [NP-1:0] hd;
        exp_meta_t em;
        exp_beat_t eb;
        @(negedge aclk);
        hm = s_meta_valid & s_meta_ready;
        hd = s_data_valid & s_data_ready;
        if (m_meta_valid && m_meta_ready) begin
            chk("meta_expected", DW'(exp_meta_q.size() > 0), DW'(1));
            if (exp_meta_q.size() > 0) begin
                em = exp_meta_q.pop_front();
                chk("meta_grant", DW'(grant_id), DW'(em.port));
                chk("meta_data", DW'(m_meta_data), DW'(em.meta));
                $display("meta  port=%0d data=%0h", grant_id, m_meta_data[23:0]);
            end
        end
        if (m_data_valid && m_data_ready) begin
            chk("beat_expected", DW'(exp_beat_q.size() > 0), DW'(1));
            if (exp_beat_q.size() > 0) begin
                eb = exp_beat_q.pop_front();
                chk("beat_data", m_data_data, eb.d);
                chk("beat_keep", DW'(m_data_keep), DW'(eb.k));
                chk("beat_last", DW'(m_data_last), DW'(eb.l));
                $display("beat  port=%0d tag=%0h last=%0d", grant_id, m_data_data[31:0], m_data_last);
            end
        end
        @(posedge aclk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (hm[p]) sm_rd[p]++;
            if (hd[p]) sd_rd[p]++;
        end
        drive();
    endtask

    // Run until the scoreboard is empty and the arbiter is idle; n returns
    // the number of cycles taken.
    task automatic drain(input string tag, input int max, output int n);
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < max) begin
            cycle();
            n++;
            done = (exp_meta_q.size() == 0) && (exp_beat_q.size() == 0) && !busy;
        end
        chk(tag, DW'(done), DW'(1));
    endtask

    task automatic do_reset();
        areset       = 1'b1;
        m_meta_ready = 1'b1;
        m_data_ready = 1'b1;
        drive();
        cycle();
        cycle();
        areset = 1'b0;
    endtask

    initial begin
        int n;
        logic [NP-1:0] er;

        // Reset state.
        do_reset();
        areset = 1'b1;
        #1;
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_grant", DW'(grant_id), DW'(0));
        chk("rst_mvalid", DW'({m_meta_valid, m_data_valid}), DW'(0));
        chk("rst_readies", DW'({s_meta_ready, s_data_ready}), DW'(0));
        areset = 1'b0;
        cycle();

        // Single packet on port 0: IDLE, META, then 3 data beats.
        pkt(0, 3, 3);
        drive();
        #1;
        chk("t1_idle_mvalid", DW'(m_meta_valid), DW'(0));
        chk("t1_idle_busy", DW'(busy), DW'(0));
        cycle();
        #1;
        chk("t1_meta_valid", DW'(m_meta_valid), DW'(1));
        chk("t1_meta_grant", DW'(grant_id), DW'(0));
        chk("t1_meta_sready", DW'(s_meta_ready), DW'(4'b0001));
        chk("t1_meta_no_data", DW'({m_data_valid, s_data_ready}), DW'(0));
        drain("t1_drain", 20, n);
        chk("t1_cycles", DW'(n), DW'(4));

        // rr_ptr is now 1: port 1 beats port 0.
        pkt(1, 1, 1);
        pkt(0, 1, 1);
        drive();
        drain("t1b_drain", 30, n);
        chk("t1b_cycles", DW'(n), DW'(6));

        // Ports 0 and 2 at reset release: 0 first, then 2.
        do_reset();
        pkt(0, 2, 2);
        pkt(2, 2, 2);
        drive();
        drain("t2_drain", 30, n);
        chk("t2_cycles", DW'(n), DW'(8));

        // All four ports, 1-beat packets: 0,1,2,3,0 at 3 cycles each.
        do_reset();
        pkt(0, 1, 1);
        pkt(1, 1, 1);
        pkt(2, 1, 1);
        pkt(3, 1, 1);
        pkt(0, 1, 1);
        drive();
        drain("t3_drain", 40, n);
        chk("t3_cycles", DW'(n), DW'(15));

        // Alternating downstream ready over a 4-beat payload on port 2.
        do_reset();
        pkt(2, 4, 4);
        drive();
        cycle();
        cycle();
        for (int i = 0; i < 8; i++) begin
            m_data_ready = (i % 2 == 1);
            #1;
            er = '0;
            er[2] = m_data_ready;
            chk("t4_sdata_ready", DW'(s_data_ready), DW'(er));
            chk("t4_smeta_ready", DW'(s_meta_ready), DW'(0));
            chk("t4_busy", DW'(busy), DW'(1));
            cycle();
        end
        m_data_ready = 1'b1;
        #1;
        chk("t4_done_idle", DW'(busy), DW'(0));

        // Port 1 payload waits 5 cycles for its metadata.
        hold_meta[1] = 1'b1;
        pkt(1, 3, 3);
        drive();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_early_sready", DW'(s_data_ready), DW'(0));
            chk("t5_early_mvalid", DW'(m_data_valid), DW'(0));
            cycle();
        end
        hold_meta[1] = 1'b0;
        drive();
        drain("t5_drain", 20, n);
        chk("t5_cycles", DW'(n), DW'(5));

        // Reset during beat 2 of 4 (rr_ptr is 2 beforehand).
        pkt(0, 4, 2);
        drive();
        cycle();
        cycle();
        cycle();
        areset = 1'b1;
        cycle();
        #1;
        chk("t6_busy", DW'(busy), DW'(0));
        chk("t6_readies", DW'({s_meta_ready, s_data_ready}), DW'(0));
        chk("t6_mvalid", DW'({m_meta_valid, m_data_valid}), DW'(0));
        chk("t6_grant", DW'(grant_id), DW'(0));
        sd_rd[0] = sd_wr[0];
        areset = 1'b0;
        drive();
        // rr_ptr back at 0 means port 0 wins over port 3.
        pkt(0, 1, 1);
        pkt(3, 1, 1);
        drive();
        drain("t6_drain", 30, n);
        chk("t6_cycles", DW'(n), DW'(6));

        chk("sb_meta_empty", DW'(exp_meta_q.size()), DW'(0));
        chk("sb_beat_empty", DW'(exp_beat_q.size()), DW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/udp_tx_meta_arbiter.md
Name: udp_tx_meta_arbiter

Overview:
- Shares one UDP TX path (176-bit metadata stream plus 512-bit payload stream) between NUM_PORTS requesters.
- Packet-granular round-robin: a requester is chosen on its metadata valid. The grant then holds for one metadata beat and all of that packet's payload beats, up to and including tlast.
- Sits in front of the UDP TX metadata/payload register slices in the network kernel; downstream sees one interleave-free packet sequence.

Parameters:
- NUM_PORTS, 4, number of requesters (1..16).
- META_WIDTH, 176, UDP metadata width in bits.
- DATA_WIDTH, 512, payload width in bits; keep width is DATA_WIDTH/8.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- s_meta_valid  in  NUM_PORTS  per-requester metadata valid.
- s_meta_ready  out  NUM_PORTS  per-requester metadata ready.
- s_meta_data  in  NUM_PORTS*META_WIDTH  metadata; port i occupies slice i.
- s_data_valid  in  NUM_PORTS  payload valid.
- s_data_ready  out  NUM_PORTS  payload ready.
- s_data_data  in  NUM_PORTS*DATA_WIDTH  payload.
- s_data_keep  in  NUM_PORTS*DATA_WIDTH/8  byte enables.
- s_data_last  in  NUM_PORTS  end of packet.
- m_meta_valid / m_meta_ready / m_meta_data  out/in/out  1/1/META_WIDTH  shared metadata output.
- m_data_valid / m_data_ready / m_data_data / m_data_keep / m_data_last  out/in/out/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8/1  shared payload output.
- grant_id  out  clog2(NUM_PORTS), min 1  currently or last granted port.
- busy  out  1  high in META or DATA state.

Behaviour:
- Clock and reset: one clock, aclk. areset is synchronous and active-high.
- Reset values: state IDLE; rr_ptr 0; grant_id 0; busy 0. All s_*_ready are 0 and m_meta_valid/m_data_valid are 0 (derived combinationally from state).
- FSM IDLE:
  - Outputs invalid, readies 0.
  - If any s_meta_valid is set, select the first set index scanning rr_ptr, rr_ptr+1, ... with wrap mod NUM_PORTS. Register it into grant_id and go to META next cycle.
  - Arbitration costs exactly 1 cycle.
- FSM META:
  - m_meta_valid = s_meta_valid[g], m_meta_data = slice g, s_meta_ready[g] = m_meta_ready. All other readies are 0.
  - On handshake (valid&&ready), go to DATA.
  - Payload is not forwarded in META; s_data_ready is all 0.
- FSM DATA:
  - m_data_* = port g fields; s_data_ready[g] = m_data_ready. Metadata readies are all 0.
  - On handshake with s_data_last[g]=1: go to IDLE and set rr_ptr = (g+1) mod NUM_PORTS.
- All forwarding is combinational through a mux on registered grant_id: zero-cycle data latency, no buffering, ready passes straight through.
- Minimum per-packet overhead: 1 IDLE cycle + 1 META beat + ≥1 DATA beat.
- Boundary conditions:
  - Requester drops meta valid while in META (protocol violation): grant is held, FSM waits; no re-arbitration.
  - Payload valid before its meta is accepted: not consumed, ready 0.
  - Simultaneous requests: rr order only; a port granted last time has lowest priority next.
  - rr wrap: ptr = NUM_PORTS-1 after port NUM_PORTS-2 finishes; the next finish at NUM_PORTS-1 wraps ptr to 0.
  - Backpressure: m_*_ready low stalls the granted requester only; the FSM holds its state.
  - areset mid-packet: abandon packet, IDLE, rr_ptr 0. The partial downstream packet is not terminated (downstream is reset with the same signal).
  - NUM_PORTS=1: grant_id constant 0; IDLE→META→DATA sequencing unchanged.
- Every metadata beat must be followed by ≥1 payload beat with last; zero-payload packets are unsupported.

Decomposition:
- Shared package udp_arb_pkg: state enum (IDLE, META, DATA), META_WIDTH_DEF=176, DATA_WIDTH_DEF=512, and a function for grant-index width.
- One sub-module, rr_priority_select: combinational; inputs a NUM_PORTS request vector and the ptr; outputs a found flag and an index. Reusable by the RX demux.

Test Plan:
- Single port 0: meta 0x..A5, 3 payload beats with last on the 3rd, m ready=1 → meta out cycle 2, data cycles 3-5 identical, keep/last preserved; rr_ptr becomes 1.
- Ports 0 and 2 both request at reset release → port 0 packet fully, 1 IDLE cycle, then port 2; grant_id 0 then 2, no interleaving.
- All 4 ports request continuously with 1-beat payloads → grant order 0,1,2,3,0 (wrap), each packet 3 cycles.
- m_data_ready toggles 1010 during a 4-beat payload → 8 cycles of DATA, s_data_ready[g] mirrors m_data_ready, other readies 0, no beat lost or duplicated.
- Port 1 asserts payload valid 5 cycles before its meta → s_data_ready[1]=0 until the META handshake, then beats flow.
- areset asserted on payload beat 2 of 4 → next cycle busy=0, all readies 0, rr_ptr 0; a new request on port 3 is granted after release.
